program_sequencer: RTL and testbench

//  Instruction-issuing side of the 8-bit datapath. It holds a loadable program memory and a
//  4-entry register file, and steps a fetch/execute/writeback FSM. For each ALU instruction it

---
 rtl/program_sequencer.sv | 159 +++++++++++++++
 tb/tb_program_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/program_sequencer.sv
// ============================================================================
//  Module   : program_sequencer
//  Purpose  : Loadable 16-word program store, 4x8 register file and a
//             fetch/exec/writeback FSM that drives an external 8-bit ALU.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module program_sequencer #(
    parameter int PROG_DEPTH = 16,
    parameter int ADDR_W     = $clog2(PROG_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [15:0]       load_data,
    input  logic              start,
    output logic [7:0]        alu_a,
    output logic [7:0]        alu_b,
    output logic [2:0]        alu_opcode,
    input  logic [7:0]        alu_result,
    input  logic              alu_carry,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] pc,
    output logic              carry_flag,
    input  logic [1:0]        dbg_sel,
    output logic [7:0]        dbg_data
);

    localparam logic [ADDR_W-1:0] C_LAST_PC = ADDR_W'(PROG_DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_HALTED = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic [7:0]        res_q, res_d;
    logic              rc_q, rc_d;
    logic              carry_q, carry_d;
    logic [3:0][7:0]   rf_q, rf_d;
    logic [15:0]       mem_q [PROG_DEPTH];

    logic              w_is_alu;
    logic              w_is_ldi;
    logic              w_exec_alu;
    logic [1:0]        w_rd;
    logic [1:0]        w_rs1;
    logic [1:0]        w_rs2;
    logic              w_mem_we;

    assign w_is_alu   = ~ir_q[15];
    assign w_is_ldi   = ir_q[15] & ~ir_q[14];
    assign w_rd       = ir_q[11:10];
    assign w_rs1      = ir_q[9:8];
    assign w_rs2      = ir_q[7:6];
    assign w_exec_alu = (state_q == S_EXEC) && w_is_alu;

    assign busy       = (state_q == S_FETCH) || (state_q == S_EXEC) || (state_q == S_WB);
    assign done       = (state_q == S_HALTED);
    assign pc         = pc_q;
    assign carry_flag = carry_q;
    assign dbg_data   = rf_q[dbg_sel];

    // ALU operands are kept at zero outside EXEC so the ALU sees a quiet bus.
    assign alu_a      = w_exec_alu ? rf_q[w_rs1] : 8'd0;
    assign alu_b      = w_exec_alu ? rf_q[w_rs2] : 8'd0;
    assign alu_opcode = w_exec_alu ? ir_q[14:12] : 3'd0;

    // Running code is protected: writes are only accepted while not busy.
    assign w_mem_we   = load_en && !busy;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            mem_q[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            res_q   <= '0;
            rc_q    <= 1'b0;
            carry_q <= 1'b0;
            rf_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            res_q   <= res_d;
            rc_q    <= rc_d;
            carry_q <= carry_d;
            rf_q    <= rf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        res_d   = res_q;
        rc_d    = rc_q;
        carry_d = carry_q;
        rf_d    = rf_q;

        case (state_q)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                end
            end
            S_FETCH: begin
                ir_d    = mem_q[pc_q];
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (w_is_alu) begin
                    res_d   = alu_result;
                    rc_d    = alu_carry;
                    state_d = S_WB;
                end else if (w_is_ldi) begin
                    res_d   = ir_q[7:0];
                    state_d = S_WB;
                end else begin
                    state_d = S_HALTED;
                end
            end
            S_WB: begin
                rf_d[w_rd] = res_q;
                if (w_is_alu) begin
                    carry_d = rc_q;
                end
                // The last word ends the program; the counter never wraps.
                if (pc_q == C_LAST_PC) begin
                    state_d = S_HALTED;
                end else begin
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_program_sequencer.sv
// ============================================================================
//  Module   : tb_program_sequencer
//  Purpose  : Scoreboard bench for program_sequencer with an ALU model and a
//             program-level reference interpreter.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_program_sequencer;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_en;
    logic [3:0]  load_addr;
    logic [15:0] load_data;
    logic        start;
    logic [7:0]  alu_a, alu_b, alu_result, dbg_data;
    logic [2:0]  alu_opcode;
    logic        alu_carry, busy, done, carry_flag;
    logic [3:0]  pc;
    logic [1:0]  dbg_sel;

    bit          clk_run  = 1'b0;
    logic        snap_req = 1'b0;
    int          cyc      = 0;
    int          n_pass   = 0;
    int          n_tot    = 0;

    typedef struct {
        string          tag;
        int             cyc;
        logic [3:0]     pc;
        logic           busy;
        logic           done;
        logic           carry;
        logic [3:0][7:0] regs;
    } exp_t;

    exp_t            sb[$];
    logic [15:0]     prog [DEPTH];
    logic [3:0][7:0] m_regs;
    logic            m_carry;

    program_sequencer #(.PROG_DEPTH(DEPTH), .ADDR_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .start      (start),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_result (alu_result),
        .alu_carry  (alu_carry),
        .busy       (busy),
        .done       (done),
        .pc         (pc),
        .carry_flag (carry_flag),
        .dbg_sel    (dbg_sel),
        .dbg_data   (dbg_data)
    );

    // External ALU: {carry, result}.
    function automatic logic [8:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {(a < b), 8'(a - b)};
            3'd2:    return {1'b0, a & b};
            3'd3:    return {1'b0, a | b};
            3'd4:    return {1'b0, a ^ b};
            3'd5:    return {a[7], 8'(a << 1)};
            3'd6:    return {a[0], 8'(a >> 1)};
            default: return (b == 8'd0) ? 9'h100 : {1'b0, 8'(a / b)};
        endcase
    endfunction

    assign {alu_carry, alu_result} = alu_f(alu_opcode, alu_a, alu_b);

    initial begin
        wait (clk_run);
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endfunction

    // Interprets the whole program; latency counts the start-sampling edge as 1.
    task automatic model_run(output int lat, output logic [3:0] fpc);
        int p;
        logic [15:0] w;
        p   = 0;
        lat = 1;
        while (1) begin
            w = prog[p];
            if (w[15:14] == 2'b11) begin
                lat += 2;
                break;
            end
            if (!w[15]) {m_carry, m_regs[w[11:10]]} = alu_f(w[14:12], m_regs[w[9:8]], m_regs[w[7:6]]);
            else        m_regs[w[11:10]] = w[7:0];
            lat += 3;
            if (p == DEPTH - 1) break;
            p++;
        end
        fpc = 4'(p);
    endtask

    // Monitor: whenever the DUT reports done (or a quiescent snapshot is requested)
    // the oldest expectation is compared against the visible state.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge done or posedge snap_req);
            #1;
            chk("scoreboard_nonempty", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb[0];
                chk({e.tag, "_busy"},  int'(busy),       int'(e.busy));
                chk({e.tag, "_done"},  int'(done),       int'(e.done));
                chk({e.tag, "_pc"},    int'(pc),         int'(e.pc));
                chk({e.tag, "_carry"}, int'(carry_flag), int'(e.carry));
                chk({e.tag, "_aluop"}, int'(alu_opcode), 0);
                chk({e.tag, "_alua"},  int'(alu_a) + int'(alu_b), 0);
                if (e.cyc >= 0) chk({e.tag, "_cycles"}, cyc, e.cyc);
                for (int i = 0; i < 4; i++) begin
                    dbg_sel = 2'(i);
                    #1;
                    chk($sformatf("%s_r%0d", e.tag, i), int'(dbg_data), int'(e.regs[i]));
                end
                sb.delete(0);
            end
        end
    end

    task automatic wait_drain(input string tag);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 3000) begin
            #1;
            k++;
        end
        chk({tag, "_drain"}, sb.size(), 0);
        sb.delete();
    endtask

    task automatic push_idle(input string tag);
        exp_t e;
        e.tag = tag; e.cyc = -1; e.pc = 4'd0; e.busy = 1'b0; e.done = 1'b0;
        e.carry = m_carry; e.regs = m_regs;
        sb.push_back(e);
        snap_req = 1'b1;
        wait_drain(tag);
        snap_req = 1'b0;
    endtask

    // mode 0: plain run, 1: start+load poke while busy, 2: reset during 3rd instruction EXEC
    task automatic run_prog(input string tag, input int mode, input bit combined);
        exp_t e;
        int lat, t0;
        logic [3:0] fpc;
        for (int i = 0; i < DEPTH - (combined ? 1 : 0); i++) begin
            @(negedge clk);
            load_en = 1'b1; load_addr = 4'(i); load_data = prog[i];
        end
        @(negedge clk);
        load_en = combined; load_addr = 4'd15; load_data = prog[15];
        start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        load_en = 1'b0; start = 1'b0;
        if (mode == 2) begin
            repeat (7) @(posedge clk);
            @(negedge clk);
            reset = 1'b0;
            m_regs = '0;
            m_carry = 1'b0;
            push_idle({tag, "_abort"});
            @(negedge clk);
            reset = 1'b1;
            return;
        end
        model_run(lat, fpc);
        e.tag = tag; e.cyc = t0 + lat; e.pc = fpc; e.busy = 1'b0; e.done = 1'b1;
        e.carry = m_carry; e.regs = m_regs;
        sb.push_back(e);
        if (mode == 1) begin
            @(negedge clk);
            start = 1'b1; load_en = 1'b1; load_addr = 4'd0; load_data = 16'hC000;
            @(negedge clk);
            start = 1'b0; load_en = 1'b0;
        end
        wait_drain(tag);
    endtask

    task automatic prog_basic(input logic [7:0] a, input logic [7:0] b);
        for (int i = 0; i < DEPTH; i++) prog[i] = 16'hC000;
        prog[0] = {8'h80, a};
        prog[1] = {8'h84, b};
        prog[2] = 16'h0840;
    endtask

    initial begin : stimulus
        int r;
        load_en = 1'b0; start = 1'b0; load_addr = '0; load_data = '0; dbg_sel = '0;
        m_regs = '0; m_carry = 1'b0;
        reset = 1'b1;
        #2 reset = 1'b0;
        #2 push_idle("reset_noclk");
        clk_run = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;

        prog_basic(8'h05, 8'h03);
        run_prog("add_5_3", 0, 1'b0);
        prog_basic(8'hF0, 8'h20);
        run_prog("add_carry", 0, 1'b0);
        for (int i = 0; i < DEPTH; i++) prog[i] = 16'h8C55;
        run_prog("no_halt", 0, 1'b0);
        prog_basic(8'h05, 8'h03);
        run_prog("busy_poke", 1, 1'b0);
        run_prog("reset_exec", 2, 1'b0);
        run_prog("restart", 0, 1'b0);

        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < DEPTH; i++) begin
                r = int'($urandom_range(0, 99));
                if (r < 5)       prog[i] = {2'b11, 14'($urandom)};
                else if (r < 40) prog[i] = {2'b10, 14'($urandom)};
                else             prog[i] = {1'b0, 15'($urandom)};
            end
            run_prog($sformatf("rand%0d", n), (n % 5 == 3) ? 1 : 0, (n % 4 == 1));
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

`default_nettype wire
